cpu_bus_responder: RTL and testbench

CPU_BUS_RESPONDER -- requirements
Module: cpu_bus_responder

---
 rtl/cpu_bus_responder.sv | 140 ++++++++++++++
 tb/tb_cpu_bus_responder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_responder.sv
// Wait-stated CPU bus target backed by a single-port synchronous RAM.
// Handshake: request strobe held until ready; ready held until strobe drops.
module cpu_bus_responder #(
    parameter int          ADDR_BITS   = 10,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_bus_clk,
    input  logic        i_bus_we,
    input  logic [31:0] i_bus_addr,
    input  logic [31:0] i_bus_data,
    output logic [31:0] o_bus_data,
    output logic        o_bus_data_ready,
    output logic        o_busy,
    output logic        o_range_err
);

    localparam int         DEPTH   = 1 << ADDR_BITS;
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_ACK} state_t;

    state_t              r_state, w_state_nxt;
    logic [3:0]          r_cnt, w_cnt_nxt;
    logic                r_phase, w_phase_nxt;
    logic                r_we;
    logic [31:0]         r_addr;
    logic [31:0]         r_wdata;
    logic                w_latch;
    logic                w_ram_wr;
    logic                w_complete;
    logic                w_err_set;
    logic                w_ack_done;
    logic [31:0]         w_idx;
    logic                w_in_range;
    logic [ADDR_BITS-1:0] w_ram_idx;
    logic [31:0]         r_ram [0:DEPTH-1];
    logic [31:0]         r_ram_q;

    // Index wraps modulo 2^32, so addresses below BASE_ADDR land far out of range.
    assign w_idx      = r_addr - BASE_ADDR;
    assign w_in_range = ((w_idx >> ADDR_BITS) == 32'd0);
    assign w_ram_idx  = w_idx[ADDR_BITS-1:0];
    assign o_busy     = (r_state != S_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_phase_nxt = r_phase;
        w_latch     = 1'b0;
        w_ram_wr    = 1'b0;
        w_complete  = 1'b0;
        w_err_set   = 1'b0;
        w_ack_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_bus_clk) begin
                    w_latch     = 1'b1;
                    w_cnt_nxt   = WAIT_LD;
                    w_phase_nxt = 1'b0;
                    w_state_nxt = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!i_bus_clk) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                    if (r_cnt <= 4'd1) begin
                        w_state_nxt = S_ACCESS;
                    end
                end
            end
            // Phase 0 drives the RAM port; phase 1 consumes its registered read data.
            S_ACCESS: begin
                if (!r_phase) begin
                    w_phase_nxt = 1'b1;
                    w_ram_wr    = r_we && w_in_range;
                    w_err_set   = !w_in_range;
                end else begin
                    w_phase_nxt = 1'b0;
                    w_complete  = 1'b1;
                    w_state_nxt = S_ACK;
                end
            end
            S_ACK: begin
                if (!i_bus_clk) begin
                    w_ack_done  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state          <= S_IDLE;
            r_cnt            <= 4'd0;
            r_phase          <= 1'b0;
            o_bus_data       <= 32'd0;
            o_bus_data_ready <= 1'b0;
            o_range_err      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_phase     <= w_phase_nxt;
            o_range_err <= w_err_set;
            if (w_complete) begin
                o_bus_data_ready <= 1'b1;
                if (!r_we) begin
                    o_bus_data <= w_in_range ? r_ram_q : 32'd0;
                end
            end else if (w_ack_done) begin
                o_bus_data_ready <= 1'b0;
            end
        end
    end

    // Request capture is data-only; the FSM decides when it is meaningful.
    always_ff @(posedge i_clk) begin
        if (w_latch) begin
            r_we    <= i_bus_we;
            r_addr  <= i_bus_addr;
            r_wdata <= i_bus_data;
        end
    end

    // Read-first single-port RAM; no reset so contents survive i_rst.
    always_ff @(posedge i_clk) begin
        if (w_ram_wr) begin
            r_ram[w_ram_idx] <= r_wdata;
        end
        r_ram_q <= r_ram[w_ram_idx];
    end

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Directed bench for cpu_bus_responder: three instances cover 2-wait, 0-wait and offset-base decoding.
module tb_cpu_bus_responder;

    logic        clk;
    logic        rst;
    logic        bclk [3];
    logic        bwe;
    logic [31:0] baddr;
    logic [31:0] bwdata;
    logic [31:0] rdata [3];
    logic        rdy   [3];
    logic        busy  [3];
    logic        rerr  [3];
    logic [31:0] last_rd [3];
    int          waits [3];
    int          n_tests;
    int          n_fail;

    cpu_bus_responder #(.ADDR_BITS(10), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) u_w2 (
        .i_clk(clk), .i_rst(rst), .i_bus_clk(bclk[0]), .i_bus_we(bwe),
        .i_bus_addr(baddr), .i_bus_data(bwdata), .o_bus_data(rdata[0]),
        .o_bus_data_ready(rdy[0]), .o_busy(busy[0]), .o_range_err(rerr[0]));

    cpu_bus_responder #(.ADDR_BITS(10), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_w0 (
        .i_clk(clk), .i_rst(rst), .i_bus_clk(bclk[1]), .i_bus_we(bwe),
        .i_bus_addr(baddr), .i_bus_data(bwdata), .o_bus_data(rdata[1]),
        .o_bus_data_ready(rdy[1]), .o_busy(busy[1]), .o_range_err(rerr[1]));

    cpu_bus_responder #(.ADDR_BITS(10), .WAIT_CYCLES(2), .BASE_ADDR(32'h100)) u_rg (
        .i_clk(clk), .i_rst(rst), .i_bus_clk(bclk[2]), .i_bus_we(bwe),
        .i_bus_addr(baddr), .i_bus_data(bwdata), .o_bus_data(rdata[2]),
        .o_bus_data_ready(rdy[2]), .o_busy(busy[2]), .o_range_err(rerr[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full handshake; inputs are scrambled right after E0 to show they were latched.
    task automatic xfer(input int u, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic exp_err,
                        input logic [31:0] exp_rd, input string tag);
        int errs;
        errs = 0;
        @(negedge clk);
        bwe = we; baddr = addr; bwdata = wd; bclk[u] = 1'b1;
        @(posedge clk);
        #1;
        bwe = ~we; baddr = ~addr; bwdata = ~wd;
        check({tag, ":busy_e0"}, 32'(busy[u]), 32'd1);
        for (int k = 1; k <= waits[u] + 2; k++) begin
            @(posedge clk);
            #1;
            if (rerr[u]) errs++;
            if (k < waits[u] + 2) check({tag, ":rdy_early"}, 32'(rdy[u]), 32'd0);
        end
        check({tag, ":rdy"}, 32'(rdy[u]), 32'd1);
        check({tag, ":err_pulses"}, 32'(errs), 32'(exp_err));
        if (!we) last_rd[u] = exp_rd;
        check({tag, ":data"}, rdata[u], last_rd[u]);
        @(negedge clk);
        bclk[u] = 1'b0;
        @(posedge clk);
        #1;
        check({tag, ":rdy_clr"}, 32'(rdy[u]), 32'd0);
        check({tag, ":idle"}, 32'(busy[u]), 32'd0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        waits   = '{2, 0, 2};
        last_rd = '{32'd0, 32'd0, 32'd0};
        bclk    = '{1'b0, 1'b0, 1'b0};
        bwe = 1'b0; baddr = 32'd0; bwdata = 32'd0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++) begin
            check("rst_data",  rdata[u],       32'd0);
            check("rst_ready", 32'(rdy[u]),    32'd0);
            check("rst_busy",  32'(busy[u]),   32'd0);
            check("rst_err",   32'(rerr[u]),   32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        xfer(0, 1'b1, 32'd5, 32'hDEAD_BEEF, 1'b0, 32'd0, "w2_wr5");
        xfer(0, 1'b0, 32'd5, 32'd0, 1'b0, 32'hDEAD_BEEF, "w2_rd5");

        xfer(1, 1'b1, 32'd0, 32'h1234_5678, 1'b0, 32'd0, "w0_wr0");
        xfer(1, 1'b0, 32'd0, 32'd0, 1'b0, 32'h1234_5678, "w0_rd0");

        xfer(2, 1'b1, 32'h4FF, 32'hCAFE_F00D, 1'b0, 32'd0, "rg_wr_top");
        xfer(2, 1'b0, 32'h4FF, 32'd0, 1'b0, 32'hCAFE_F00D, "rg_rd_top");
        xfer(2, 1'b0, 32'h0FF, 32'd0, 1'b1, 32'd0, "rg_rd_below");
        xfer(2, 1'b0, 32'h500, 32'd0, 1'b1, 32'd0, "rg_rd_above");
        xfer(2, 1'b1, 32'h0FF, 32'h5555_5555, 1'b1, 32'd0, "rg_wr_below");
        xfer(2, 1'b0, 32'h4FF, 32'd0, 1'b0, 32'hCAFE_F00D, "rg_rd_top_kept");

        // Abort: strobe dropped while waiting.
        xfer(0, 1'b1, 32'd7, 32'h0000_0011, 1'b0, 32'd0, "ab_prewr");
        @(negedge clk);
        bwe = 1'b1; baddr = 32'd7; bwdata = 32'hAAAA_AAAA; bclk[0] = 1'b1;
        @(posedge clk);
        #1;
        bclk[0] = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            check("ab_no_rdy", 32'(rdy[0]), 32'd0);
            check("ab_no_err", 32'(rerr[0]), 32'd0);
        end
        check("ab_idle", 32'(busy[0]), 32'd0);
        xfer(0, 1'b0, 32'd7, 32'd0, 1'b0, 32'h0000_0011, "ab_rd7");

        // Held request, then back-to-back acceptance after the release edge.
        @(negedge clk);
        bwe = 1'b0; baddr = 32'd5; bclk[0] = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            check("hold_rdy_time", 32'(rdy[0]), (k == 4) ? 32'd1 : 32'd0);
        end
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check("hold_rdy",  32'(rdy[0]),  32'd1);
            check("hold_busy", 32'(busy[0]), 32'd1);
            check("hold_data", rdata[0],     32'hDEAD_BEEF);
        end
        @(negedge clk);
        bclk[0] = 1'b0;
        @(posedge clk);
        #1;
        check("hold_rdy_clr", 32'(rdy[0]),  32'd0);
        check("hold_idle",    32'(busy[0]), 32'd0);
        @(negedge clk);
        baddr = 32'd7; bclk[0] = 1'b1;
        @(posedge clk);
        #1;
        check("next_accept", 32'(busy[0]), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            check("next_rdy_time", 32'(rdy[0]), (k == 4) ? 32'd1 : 32'd0);
        end
        check("next_data", rdata[0], 32'h0000_0011);
        last_rd[0] = 32'h0000_0011;
        @(negedge clk);
        bclk[0] = 1'b0;
        @(posedge clk);

        // Reset during the wait states of a write.
        xfer(0, 1'b1, 32'd3, 32'h0000_0033, 1'b0, 32'd0, "rs_prewr");
        xfer(0, 1'b0, 32'd3, 32'd0, 1'b0, 32'h0000_0033, "rs_prerd");
        @(negedge clk);
        bwe = 1'b1; baddr = 32'd3; bwdata = 32'h9999_9999; bclk[0] = 1'b1;
        @(posedge clk);
        #1;
        check("rs_busy_pre", 32'(busy[0]), 32'd1);
        rst = 1'b1;
        bclk[0] = 1'b0;
        #1;
        check("rs_data",  rdata[0],     32'd0);
        check("rs_ready", 32'(rdy[0]),  32'd0);
        check("rs_busy",  32'(busy[0]), 32'd0);
        check("rs_err",   32'(rerr[0]), 32'd0);
        last_rd[0] = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        xfer(0, 1'b0, 32'd3, 32'd0, 1'b0, 32'h0000_0033, "rs_rd3");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
